// File: rtl/color_sequencer.sv
// ============================================================================
// Module   : color_sequencer
// Brief    : Palette index/colour sequencer with dwell, ping-pong, manual
//            step and freeze modes for the breathing-light datapath.
// Revision : 1.0
// ============================================================================
`default_nettype none

module color_sequencer #(
  parameter int N_COLORS = 6,
  parameter int IDX_W    = 3,
  parameter int COLOR_W  = 3,
  parameter int HOLD_W   = 8,
  // PURPLE, BLUE, GREEN, YELLOW, ORANGE, RED (entry 0 in the LSBs)
  parameter logic [N_COLORS*COLOR_W-1:0] PALETTE = {3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1}
) (
  input  logic               clk_div_i,
  input  logic               rst_ni,
  input  logic               en_i,
  input  logic [1:0]         mode_i,
  input  logic               step_i,
  input  logic [HOLD_W-1:0]  hold_i,
  output logic [IDX_W-1:0]   idx_o,
  output logic [COLOR_W-1:0] color_o,
  output logic               dir_o,
  output logic               wrap_o
);

  localparam logic [1:0]       c_MODE_FWD  = 2'b00;
  localparam logic [1:0]       c_MODE_PING = 2'b01;
  localparam logic [1:0]       c_MODE_MAN  = 2'b10;
  localparam logic [IDX_W-1:0] c_LAST      = IDX_W'(N_COLORS - 1);

  logic [IDX_W-1:0]   r_idx;
  logic [COLOR_W-1:0] r_color;
  logic               r_dir;
  logic               r_wrap;
  logic [HOLD_W-1:0]  r_cnt;
  logic [1:0]         r_mode;
  logic               r_mode_vld;

  logic               w_dwell_mode;
  logic               w_mode_chg;
  logic               w_adv;
  logic               w_up;
  logic [IDX_W-1:0]   w_nxt_pp;
  logic               w_dir_pp;
  logic [IDX_W-1:0]   w_nxt_fwd;
  logic [IDX_W-1:0]   w_nxt_idx;
  logic [COLOR_W-1:0] w_nxt_color;

  assign w_dwell_mode = (mode_i == c_MODE_FWD) || (mode_i == c_MODE_PING);
  // r_mode_vld keeps the first cycle after reset from looking like a mode change
  assign w_mode_chg   = r_mode_vld && (mode_i != r_mode);
  // >= also covers a dwell counter stranded above a freshly lowered hold_i
  assign w_adv        = en_i && ((w_dwell_mode && (r_cnt >= hold_i)) ||
                                 ((mode_i == c_MODE_MAN) && step_i));

  // Bounce at either end, including entering ping-pong while sitting at the top
  assign w_up      = r_dir ? (r_idx != c_LAST) : (r_idx == '0);
  assign w_nxt_pp  = w_up ? r_idx + 1'b1 : r_idx - 1'b1;
  assign w_dir_pp  = w_up ? (w_nxt_pp != c_LAST) : (w_nxt_pp == '0);
  assign w_nxt_fwd = (r_idx == c_LAST) ? '0 : r_idx + 1'b1;
  assign w_nxt_idx = (mode_i == c_MODE_PING) ? w_nxt_pp : w_nxt_fwd;

  always_comb begin
    w_nxt_color = '0;
    for (int k = 0; k < N_COLORS; k++) begin
      if (w_nxt_idx == IDX_W'(k)) w_nxt_color = PALETTE[k*COLOR_W +: COLOR_W];
    end
  end

  always_ff @(posedge clk_div_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_idx      <= '0;
      r_color    <= PALETTE[COLOR_W-1:0];
      r_dir      <= 1'b1;
      r_wrap     <= 1'b0;
      r_cnt      <= '0;
      r_mode     <= c_MODE_FWD;
      r_mode_vld <= 1'b0;
    end else begin
      r_mode     <= mode_i;
      r_mode_vld <= 1'b1;
      r_wrap     <= w_adv && (w_nxt_idx == '0) && (r_idx != '0);
      if (en_i) begin
        if (w_mode_chg || !w_dwell_mode || w_adv) r_cnt <= '0;
        else                                      r_cnt <= r_cnt + 1'b1;
      end
      if (w_adv) begin
        r_idx   <= w_nxt_idx;
        r_color <= w_nxt_color;
      end
      if (mode_i != c_MODE_PING) r_dir <= 1'b1;
      else if (w_adv)            r_dir <= w_dir_pp;
    end
  end

  assign idx_o   = r_idx;
  assign color_o = r_color;
  assign dir_o   = r_dir;
  assign wrap_o  = r_wrap;

endmodule

`default_nettype wire

// File: tb/tb_color_sequencer.sv
// ============================================================================
// Module   : tb_color_sequencer
// Brief    : Scoreboard bench for color_sequencer against an integer model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_color_sequencer;

  localparam int N = 6;

  logic       clk_div_i = 1'b0;
  logic       rst_ni    = 1'b0;
  logic       en_i      = 1'b0;
  logic [1:0] mode_i    = 2'b00;
  logic       step_i    = 1'b0;
  logic [7:0] hold_i    = 8'd0;
  logic [2:0] idx_o;
  logic [2:0] color_o;
  logic       dir_o;
  logic       wrap_o;

  color_sequencer dut (
    .clk_div_i (clk_div_i),
    .rst_ni    (rst_ni),
    .en_i      (en_i),
    .mode_i    (mode_i),
    .step_i    (step_i),
    .hold_i    (hold_i),
    .idx_o     (idx_o),
    .color_o   (color_o),
    .dir_o     (dir_o),
    .wrap_o    (wrap_o)
  );

  always #5 clk_div_i = ~clk_div_i;

  typedef struct {
    int idx;
    int color;
    int dir;
    int wrap;
  } exp_t;

  exp_t q[$];
  int   checks   = 0;
  int   failures = 0;

  // Reference state: palette position, travel direction, cycles spent on colour
  int m_idx, m_dir, m_cnt, m_prev;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d @%0t", name, act, req, $time);
    end
  endtask

  task automatic bound_expired(input string name);
    checks++;
    failures++;
    $display("FAIL %s actual=bound-expired required=condition-reached", name);
  endtask

  function automatic int colour_of(input int k);
    return k + 1;  // RED=1 ... PURPLE=6
  endfunction

  task automatic model_reset();
    m_idx = 0; m_dir = 1; m_cnt = 0; m_prev = -1;
  endtask

  task automatic cyc(input bit en, input int mode, input bit step, input int hold);
    int   adv, nidx, ndir, d;
    exp_t e;
    @(negedge clk_div_i);
    en_i = en; mode_i = mode[1:0]; step_i = step; hold_i = hold[7:0];
    adv = 0;
    if (en) begin
      if (mode < 2)       adv = (m_cnt >= hold) ? 1 : 0;
      else if (mode == 2) adv = step ? 1 : 0;
    end
    if (en) m_cnt = ((m_prev >= 0 && m_prev != mode) || mode >= 2 || adv != 0) ? 0 : m_cnt + 1;
    nidx = m_idx;
    ndir = m_dir;
    if (adv != 0) begin
      if (mode == 1) begin
        d = (m_dir != 0) ? 1 : -1;
        if (m_idx + d < 0 || m_idx + d > N - 1) d = -d;
        nidx = m_idx + d;
        ndir = (nidx == N - 1) ? 0 : (nidx == 0) ? 1 : (d > 0 ? 1 : 0);
      end else begin
        nidx = (m_idx + 1) % N;
      end
    end
    if (mode != 1) ndir = 1;
    e.idx   = nidx;
    e.color = colour_of(nidx);
    e.dir   = ndir;
    e.wrap  = (adv != 0 && nidx == 0 && m_idx != 0) ? 1 : 0;
    m_idx = nidx; m_dir = ndir; m_prev = mode;
    q.push_back(e);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_idx"},   int'(idx_o),   0);
    chk({tag, "_color"}, int'(color_o), colour_of(0));
    chk({tag, "_dir"},   int'(dir_o),   1);
    chk({tag, "_wrap"},  int'(wrap_o),  0);
  endtask

  // Pulse reset low mid-cycle, after the last pending expectation was consumed
  task automatic async_reset(input string tag);
    @(posedge clk_div_i);
    #2 rst_ni = 1'b0;
    #1 check_reset_outputs(tag);
    @(posedge clk_div_i);
    #2 rst_ni = 1'b1;
    model_reset();
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk_div_i);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("sb_idx",   int'(idx_o),   e.idx);
        chk("sb_color", int'(color_o), e.color);
        chk("sb_dir",   int'(dir_o),   e.dir);
        chk("sb_wrap",  int'(wrap_o),  e.wrap);
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    int n;
    model_reset();
    en_i = 1'b1; hold_i = 8'd3;
    repeat (3) @(posedge clk_div_i);
    #1 check_reset_outputs("reset");
    @(posedge clk_div_i);
    #2 rst_ni = 1'b1;

    // Dwell after release: idx stays 0 for hold_i+1 cycles
    repeat (8) cyc(1, 0, 0, 3);

    // Forward wrap with 3-cycle dwell
    repeat (24) cyc(1, 0, 0, 2);

    // Ping-pong every cycle from 0
    async_reset("rst_pp");
    repeat (14) cyc(1, 1, 0, 0);

    // Manual: 7 steps with gaps, long dwell ignored
    async_reset("rst_man");
    for (int i = 0; i < 7; i++) begin
      cyc(1, 2, 1, 255);
      repeat (2) cyc(1, 2, 0, 255);
    end
    @(posedge clk_div_i);
    #1 chk("manual_final_idx", int'(idx_o), 1);

    // Pause mid-dwell then resume
    repeat (3) cyc(1, 0, 0, 7);
    repeat (10) cyc(0, 0, 0, 7);
    repeat (10) cyc(1, 0, 0, 7);

    // Freeze ignores step and dwell
    repeat (15) cyc(1, 3, 1'($urandom_range(0, 1)), 0);

    // Lower hold 9 -> 1 while cnt sits at 5
    n = 0;
    while (m_cnt != 5 && n < 30) begin cyc(1, 0, 0, 9); n++; end
    if (m_cnt != 5) bound_expired("hold_lower_setup");
    cyc(1, 0, 0, 1);

    // Asynchronous reset while showing idx 3
    n = 0;
    while (m_idx != 3 && n < 20) begin cyc(1, 0, 0, 0); n++; end
    if (m_idx != 3) bound_expired("async_rst_setup");
    async_reset("rst_at3");

    // Leave ping-pong while descending at idx 3
    n = 0;
    while (!(m_idx == 3 && m_dir == 0) && n < 40) begin cyc(1, 1, 0, 0); n++; end
    if (!(m_idx == 3 && m_dir == 0)) bound_expired("pp_exit_setup");
    cyc(1, 0, 0, 0);
    @(posedge clk_div_i);
    #1 chk("pp_exit_idx", int'(idx_o), 4);
    chk("pp_exit_dir", int'(dir_o), 1);

    // Randomized soak
    begin
      int mode, hold;
      mode = 0; hold = 1;
      for (int i = 0; i < 1200; i++) begin
        if ($urandom_range(0, 9) == 0) mode = $urandom_range(0, 3);
        if ($urandom_range(0, 11) == 0) hold = $urandom_range(0, 5);
        cyc(($urandom_range(0, 5) != 0), mode, 1'($urandom_range(0, 1)), hold);
        if ($urandom_range(0, 299) == 0) async_reset("rst_rand");
      end
    end

    repeat (3) @(posedge clk_div_i);
    #2 chk("queue_drained", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
